float_accumulator: RTL and testbench

FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

---
 rtl/float_accumulator_pkg.sv | 26 ++
 rtl/float_accumulator_if.sv | 19 +
 rtl/float_accumulator_float_add.sv | 85 ++++++++
 rtl/float_accumulator.sv | 137 +++++++++++++
 tb/tb_float_accumulator.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/float_accumulator_pkg.sv
// Shared types and constants for the float accumulator: FSM states, adder
// latency, and float field positions.
package float_accumulator_pkg;

  typedef enum logic [2:0] {
    ACCUM,
    COLLECT,
    REDUCE1,
    REDUCE2,
    OUT
  } state_t;

  localparam int ADD_LAT           = 4;
  localparam int DEF_MANTISSA_SIZE = 23;
  localparam int DEF_EXPONENT_SIZE = 8;

  // Float layout is {sign, exponent, mantissa}, mantissa at bit 0.
  function automatic int exp_lsb(input int mantissa_size);
    return mantissa_size;
  endfunction

  function automatic int sign_pos(input int mantissa_size, input int exponent_size);
    return mantissa_size + exponent_size;
  endfunction

endpackage

// File: rtl/float_accumulator_if.sv
// Stream-in / sum-out handshake bundle for the float accumulator.
interface float_accumulator_if
  import float_accumulator_pkg::*;
#(
  parameter int FLOAT_SIZE = 1 + DEF_EXPONENT_SIZE + DEF_MANTISSA_SIZE
);
  logic                  s_valid;
  logic                  s_ready;
  logic [FLOAT_SIZE-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [FLOAT_SIZE-1:0] m_data;

  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data);
endinterface

// File: rtl/float_accumulator_float_add.sv
// Four-stage pipelined float adder: align, add, normalise, output register.
// Subnormals flush to zero; the result is truncated toward zero.
module FloatAdd
  import float_accumulator_pkg::*;
#(
  parameter int MANTISSA_SIZE       = DEF_MANTISSA_SIZE,
  parameter int EXPONENT_SIZE       = DEF_EXPONENT_SIZE,
  parameter int ENABLE_OPTIMIZATION = 0
) (
  input  logic                                     clk,
  input  logic [MANTISSA_SIZE+EXPONENT_SIZE:0]     a,
  input  logic [MANTISSA_SIZE+EXPONENT_SIZE:0]     b,
  output logic [MANTISSA_SIZE+EXPONENT_SIZE:0]     y
);
  localparam int M    = MANTISSA_SIZE;
  localparam int E    = EXPONENT_SIZE;
  localparam int SGN  = sign_pos(M, E);
  localparam int ELSB = exp_lsb(M);
  // Optimised builds narrow the alignment datapath to a single guard bit.
  localparam int G    = (ENABLE_OPTIMIZATION != 0) ? 1 : 3;
  localparam int XW   = M + 1 + G;

  logic          s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
  logic [E-1:0]  s1_exp_d, s1_exp_q;
  logic [XW-1:0] s1_mx_d, s1_mx_q, s1_my_d, s1_my_q;
  logic          s2_sign_q;
  logic [E-1:0]  s2_exp_q;
  logic [XW:0]   s2_sum_d, s2_sum_q;
  logic [SGN:0]  s3_res_d, s3_res_q;

  logic          a_big;
  logic [E-1:0]  ea, eb, ey;
  logic [XW-1:0] fa, fb, fy;
  logic [E:0]    lz;
  logic [XW-1:0] norm;

  always_comb begin
    ea        = a[ELSB +: E];
    eb        = b[ELSB +: E];
    fa        = (ea == '0) ? '0 : {1'b1, a[M-1:0], {G{1'b0}}};
    fb        = (eb == '0) ? '0 : {1'b1, b[M-1:0], {G{1'b0}}};
    a_big     = a[SGN-1:0] >= b[SGN-1:0];
    s1_sign_d = a_big ? a[SGN] : b[SGN];
    s1_sub_d  = a[SGN] ^ b[SGN];
    s1_exp_d  = a_big ? ea : eb;
    ey        = a_big ? eb : ea;
    s1_mx_d   = a_big ? fa : fb;
    fy        = a_big ? fb : fa;
    s1_my_d   = fy >> (s1_exp_d - ey);
  end

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                             : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});

  always_comb begin
    lz = '0;
    for (int i = 0; i < XW; i++) begin
      if (s2_sum_q[i]) lz = (E+1)'(XW - 1 - i);
    end
    norm     = s2_sum_q[XW-1:0] << lz;
    s3_res_d = '0;
    if (s2_sum_q[XW]) begin
      if (s2_exp_q == {{(E-1){1'b1}}, 1'b0}) s3_res_d = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
      else s3_res_d = {s2_sign_q, s2_exp_q + E'(1), s2_sum_q[XW-1 -: M]};
    end else if (s2_sum_q[XW-1:0] != '0 && {1'b0, s2_exp_q} > lz) begin
      s3_res_d = {s2_sign_q, s2_exp_q - lz[E-1:0], M'(norm >> G)};
    end
  end

  // NOTE: pure datapath pipeline with no reset; consumers qualify its output
  // with their own valid state, so stale contents are never used.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_sub_q  <= s1_sub_d;
    s1_exp_q  <= s1_exp_d;
    s1_mx_q   <= s1_mx_d;
    s1_my_q   <= s1_my_d;
    s2_sign_q <= s1_sign_q;
    s2_exp_q  <= s1_exp_q;
    s2_sum_q  <= s2_sum_d;
    s3_res_q  <= s3_res_d;
    y         <= s3_res_q;
  end

endmodule

// File: rtl/float_accumulator.sv
// Packet float summer: four interleaved partial sums circulate through one
// pipelined adder, then a two-level reduction produces the packet total.
module float_accumulator
  import float_accumulator_pkg::*;
#(
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE,
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  float_accumulator_if.slave  bus
);
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam logic [2:0] LAT = 3'(ADD_LAT);
  typedef logic [FLOAT_SIZE-1:0] flt_t;

  state_t     state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [3:0] lane_valid_q, lane_valid_d;
  logic [2:0] wait_q, wait_d;
  flt_t       r_q [4];
  flt_t       r_d [4];
  flt_t       m_data_q, m_data_d;
  flt_t       add_a, add_b, add_y;
  logic       beat;

  assign bus.s_ready = (state_q == ACCUM) && !reset;
  assign bus.m_valid = (state_q == OUT) && !reset;
  assign bus.m_data  = m_data_q;
  assign beat        = bus.s_valid && bus.s_ready;

  FloatAdd #(
    .MANTISSA_SIZE      (MANTISSA_SIZE),
    .EXPONENT_SIZE      (EXPONENT_SIZE),
    .ENABLE_OPTIMIZATION(0)
  ) u_add (
    .clk(clk),
    .a  (add_a),
    .b  (add_b),
    .y  (add_y)
  );

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    lane_valid_d = lane_valid_q;
    wait_d       = wait_q;
    r_d          = r_q;
    m_data_d     = m_data_q;
    add_a        = '0;
    add_b        = '0;
    unique case (state_q)
      ACCUM: begin
        lane_d = lane_q + 2'd1;
        if (beat) begin
          add_a                = bus.s_data;
          lane_valid_d[lane_q] = 1'b1;
        end
        if (lane_valid_q[lane_q]) add_b = add_y;
        if (beat && bus.s_last) begin
          state_d = COLLECT;
          wait_d  = '0;
        end
      end
      COLLECT: begin
        // The adder output this cycle belongs to the lane now selected.
        lane_d      = lane_q + 2'd1;
        r_d[lane_q] = lane_valid_q[lane_q] ? add_y : '0;
        wait_d      = wait_q + 3'd1;
        if (wait_q == 3'd3) begin
          state_d = REDUCE1;
          wait_d  = '0;
        end
      end
      REDUCE1: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == 3'd0) begin
          add_a = r_q[0];
          add_b = r_q[1];
        end
        if (wait_q == 3'd1) begin
          add_a = r_q[2];
          add_b = r_q[3];
        end
        if (wait_q == LAT)         r_d[0] = add_y;
        if (wait_q == LAT + 3'd1)  r_d[2] = add_y;
        // One idle slot pads the total to a fixed 16-cycle result latency.
        if (wait_q == LAT + 3'd2) begin
          state_d = REDUCE2;
          wait_d  = '0;
        end
      end
      REDUCE2: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == 3'd0) begin
          add_a = r_q[0];
          add_b = r_q[2];
        end
        if (wait_q == LAT) begin
          m_data_d = add_y;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          state_d      = ACCUM;
          lane_d       = '0;
          lane_valid_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      lane_q       <= '0;
      lane_valid_q <= '0;
      wait_q       <= '0;
      m_data_q     <= '0;
      r_q          <= '{default: '0};
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      lane_valid_q <= lane_valid_d;
      wait_q       <= wait_d;
      m_data_q     <= m_data_d;
      r_q          <= r_d;
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator: table of packets with hand-computed
// sums, plus back-pressure and mid-reduction reset sequences.
module tb_float_accumulator;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  float_accumulator_if #(.FLOAT_SIZE(32)) bus ();

  float_accumulator #(
    .MANTISSA_SIZE(23),
    .EXPONENT_SIZE(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string                nm;
    int                   n;
    logic [7:0][31:0]     beats;
    bit                   gaps;
    logic [31:0]          expv;
  } vec_t;

  vec_t vecs [7];
  int   lat;
  bit   ready_ok, hold_ok, rdy_low, mv_high, stale_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int n, input logic [255:0] b,
                              input bit g, input logic [31:0] e);
    vec_t v;
    v.nm = nm; v.n = n; v.beats = b; v.gaps = g; v.expv = e;
    return v;
  endfunction

  // Entered just after a clock edge; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic last, input int gap,
                           inout bit rdy_seen);
    logic rdy;
    bus.s_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (bus.s_ready !== 1'b1) rdy_seen = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      if (rdy !== 1'b1) rdy_seen = 1'b0;
      @(posedge clk);
      if (rdy === 1'b1) break;
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Counts edges from the s_last acceptance edge until m_valid shows.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      cycles++;
      #1;
      if (bus.m_valid === 1'b1) break;
    end
  endtask

  task automatic handshake(input string nm);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    check({nm, "_ready_after_hs"}, 32'(bus.s_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("seq1to8", 8, {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
                 1'b0, 32'h42100000);
    vecs[1] = mk("single3", 1, {224'h0, 32'h40400000}, 1'b0, 32'h40400000);
    vecs[2] = mk("cancel", 2, {192'h0, 32'hBFC00000, 32'h3FC00000}, 1'b0, 32'h00000000);
    vecs[3] = mk("gaps5", 5, {96'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h3F800000}, 1'b1, 32'h40A00000);
    vecs[4] = mk("align", 2, {192'h0, 32'h3E800000, 32'h40200000}, 1'b0, 32'h40300000);
    vecs[5] = mk("negsum", 2, {192'h0, 32'hC0000000, 32'hBF800000}, 1'b0, 32'hC0400000);
    vecs[6] = mk("subnorm", 2, {192'h0, 32'hBE800000, 32'h3F800000}, 1'b0, 32'h3F400000);

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", 32'(bus.s_ready), 32'd0);
    check("reset_m_valid", 32'(bus.m_valid), 32'd0);
    check("reset_m_data", bus.m_data, 32'h0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.s_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      ready_ok = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) begin
        send_beat(vecs[v].beats[i], (i == vecs[v].n - 1),
                  vecs[v].gaps ? int'($urandom_range(0, 6)) : 0, ready_ok);
      end
      wait_result(lat);
      check({vecs[v].nm, "_latency"}, 32'(lat), 32'd16);
      check({vecs[v].nm, "_data"}, bus.m_data, vecs[v].expv);
      check({vecs[v].nm, "_ready_before_last"}, 32'(ready_ok), 32'd1);
      handshake(vecs[v].nm);
    end

    // Back-pressure: hold m_ready low while upstream presents a beat.
    ready_ok = 1'b1;
    send_beat(32'h3F800000, 1'b0, 0, ready_ok);
    send_beat(32'h40000000, 1'b1, 0, ready_ok);
    wait_result(lat);
    check("hold_latency", 32'(lat), 32'd16);
    check("hold_data_first", bus.m_data, 32'h40400000);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h40800000;
    bus.s_last  = 1'b1;
    hold_ok = 1'b1; rdy_low = 1'b1; mv_high = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_data !== 32'h40400000) hold_ok = 1'b0;
      if (bus.s_ready !== 1'b0) rdy_low = 1'b0;
      if (bus.m_valid !== 1'b1) mv_high = 1'b0;
    end
    check("hold_data_stable", 32'(hold_ok), 32'd1);
    check("hold_s_ready_low", 32'(rdy_low), 32'd1);
    check("hold_m_valid_high", 32'(mv_high), 32'd1);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    check("hold_ready_after_hs", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_result(lat);
    check("held_beat_latency", 32'(lat), 32'd16);
    check("held_beat_data", bus.m_data, 32'h40800000);
    handshake("held_beat");

    // Reset during REDUCE1 must discard the packet in flight.
    ready_ok = 1'b1;
    send_beat(32'h3F800000, 1'b0, 0, ready_ok);
    send_beat(32'h40000000, 1'b1, 0, ready_ok);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_m_valid", 32'(bus.m_valid), 32'd0);
    check("midreset_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_ready_after", 32'(bus.s_ready), 32'd1);
    stale_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0) stale_ok = 1'b0;
    end
    check("midreset_no_stale", 32'(stale_ok), 32'd1);
    @(posedge clk);
    #1;
    ready_ok = 1'b1;
    send_beat(32'h40000000, 1'b0, 0, ready_ok);
    send_beat(32'h40000000, 1'b1, 0, ready_ok);
    wait_result(lat);
    check("post_reset_latency", 32'(lat), 32'd16);
    check("post_reset_data", bus.m_data, 32'h40800000);
    handshake("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
